bin2bcd_seq: RTL and testbench

Sequential double-dabble binary-to-BCD converter. It sits between the GPO display-source select and the four hex_to_7seg decoders, so the 7-segment bank can show decimal instead of hex. A start/busy/done handshake is used, with one shift per clock. The result register holds steady between conversions, so led_mux always scans a stable value.

---
 rtl/bin2bcd_pkg.sv | 13 +
 rtl/bin2bcd_seq_adj.sv | 11 +
 rtl/bin2bcd_seq.sv | 104 ++++++++++
 tb/tb_bin2bcd_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared FSM state type, digit-adjust constants and counter sizing
package bin2bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// bcd_digit_adj: double-dabble add-3 correction for one BCD digit (4-bit wrap)
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= ADJ_THRESH) ? d + ADJ_ADD : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one shift per clock.
// Define BIN2BCD_BLANK_EN to add the registered leading-zero mask output blank.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int CW = cnt_width(BIN_W);
    localparam int SW = 4 * DIGITS;

    if (BIN_W < 4 || DIGITS < 1) begin : g_bad_params
        $error("bin2bcd_seq: BIN_W must be >= 4 and DIGITS >= 1");
    end

    state_t          state, state_nx;
    logic [BIN_W-1:0] bin_sr;
    logic [SW-1:0]   scr, scr_adj, scr_sh;
    logic [CW-1:0]   cnt;
    logic            sov, sov_nx, last;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (.d(scr[4*i +: 4]), .q(scr_adj[4*i +: 4]));
    end

    // The bit leaving the adjusted scratch is lost weight, so it marks overflow.
    assign scr_sh = {scr_adj[SW-2:0], bin_sr[BIN_W-1]};
    assign sov_nx = sov | scr_adj[SW-1];
    assign last   = (cnt == CW'(1));
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE)  ? (start ? SHIFT : IDLE) :
                   (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nx;
    logic              zrun;

    always_comb begin
        blank_nx = '0;
        zrun     = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zrun        = zrun & (scr_sh[4*i +: 4] == 4'd0);
            blank_nx[i] = zrun;
        end
    end
`endif

    // Results are loaded on the final shift so they are valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr  <= '0;
            scr     <= '0;
            cnt     <= '0;
            sov     <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank   <= '0;
`endif
        end else if (state == IDLE && start) begin
            bin_sr <= bin_in;
            scr    <= '0;
            sov    <= 1'b0;
            cnt    <= CW'(BIN_W);
        end else if (state == SHIFT) begin
            bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
            scr    <= scr_sh;
            sov    <= sov_nx;
            cnt    <= cnt - CW'(1);
            if (last) begin
                bcd_out <= scr_sh;
                ovf     <= sov_nx;
`ifdef BIN2BCD_BLANK_EN
                blank   <= blank_nx;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq (BIN_W=16, DIGITS=4).
module tb_bin2bcd_seq;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        busy, done, ovf;
    logic [15:0] bcd_out;
`ifdef BIN2BCD_BLANK_EN
    logic [3:0]  blank;
`endif

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
`ifdef BIN2BCD_BLANK_EN
        , .blank(blank)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] v);
        exp_t e;
        int   r;
        logic z;
        r     = int'(v) % 10000;
        e.ovf = (v > 16'd9999);
        e.bcd = '0;
        for (int i = 0; i < 4; i++) begin
            e.bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        e.blank = '0;
        z = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            z = z & (e.bcd[4*i +: 4] == 4'd0);
            e.blank[i] = z;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("bcd_out", {16'd0, bcd_out}, {16'd0, e.bcd});
                check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`ifdef BIN2BCD_BLANK_EN
                check("blank", {28'd0, blank}, {28'd0, e.blank});
`endif
            end
        end
    end

    // Called at a negedge while the DUT is idle; returns one negedge later.
    task automatic go(input logic [15:0] v);
        start  = 1'b1;
        bin_in = v;
        q.push_back(model(v));
        @(negedge clk);
        start  = 1'b0;
        bin_in = 16'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int lat = 1;
        int nb  = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 17);
        check({tag, "_busy_cycles"}, nb, 16);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic convert(input logic [15:0] v, input string tag);
        go(v);
        wait_done(tag);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bcd", {16'd0, bcd_out}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);

        convert(16'h0000, "zero");
        convert(16'h04D2, "v1234");
        convert(16'h270F, "v9999");
        convert(16'h2710, "v10000");
        convert(16'hFFFF, "v65535");
        convert(16'h0001, "v1");
        check("ovf_cleared", {31'd0, ovf}, 32'd0);

        // Pulses on cycles 3 and 17 land in SHIFT and DONE and must be ignored.
        go(16'h0063);
        for (int c = 2; c <= 17; c++) begin
            @(negedge clk);
            start  = (c == 3 || c == 17);
            bin_in = 16'h1111;
        end
        check("done_at_17", {31'd0, done}, 32'd1);
        @(negedge clk);
        go(16'h0315);
        wait_done("b2b");
        @(negedge clk);

        // Reset mid-conversion discards it without a done pulse.
        go(16'h1000);
        for (int c = 2; c <= 8; c++) @(negedge clk);
        rst = 1'b1;
        void'(q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        check("abort_bcd", {16'd0, bcd_out}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (20) @(negedge clk);
        convert(16'h0007, "after_abort");

        convert(16'h0400, "v1024");
        for (int k = 0; k < 6; k++) convert(16'($urandom), "rand");

        repeat (5) @(negedge clk);
        check("pending", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
